// File: rtl/bram_b_arbiter_pkg.sv
// Shared encodings for the BRAM port-B arbiter: FSM states and owner identifiers.
package bram_b_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } arb_state_e;

  localparam logic OWN_MATRIX = 1'b0;
  localparam logic OWN_HOST   = 1'b1;

endpackage

// File: rtl/bram_b_arbiter_if.sv
// Port-B arbiter bus: matrix requester, host requester and the BRAM port-B pins.
interface bram_b_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              we_b;
  logic [DATA_W-1:0] q_b;
  logic              busy;

  // Arbiter side
  modport slave (
    input  m_req, m_addr, h_req, h_we, h_addr, h_wdata, q_b,
    output m_gnt, m_rvalid, m_rdata, h_gnt, h_rvalid, h_rdata,
    output addr_b, data_b, we_b, busy
  );

  // Requesters and BRAM side
  modport master (
    output m_req, m_addr, h_req, h_we, h_addr, h_wdata, q_b,
    input  m_gnt, m_rvalid, m_rdata, h_gnt, h_rvalid, h_rdata,
    input  addr_b, data_b, we_b, busy
  );

endinterface

// File: rtl/bram_b_arbiter_rr_pick2.sv
// Two-way winner select: round-robin against last_owner, or fixed matrix priority.
module rr_pick2
  import bram_b_arbiter_pkg::*;
#(
  parameter int MATRIX_PRIO = 0
) (
  input  logic m_req,
  input  logic h_req,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = m_req | h_req;
    winner = OWN_MATRIX;
    if (m_req && h_req) begin
      winner = (MATRIX_PRIO != 0) ? OWN_MATRIX : ~last_owner;
    end else if (h_req) begin
      winner = OWN_HOST;
    end
  end

endmodule

// File: rtl/bram_b_arbiter.sv
// Shares BRAM port B between the matrix scan reader and the host loader/debug port.
module bram_b_arbiter
  import bram_b_arbiter_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MATRIX_PRIO = 0
) (
  input logic             clk,
  input logic             reset,
  bram_b_arbiter_if.slave bus
);

  arb_state_e        state_reg, state_next;
  logic              owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              we_reg, we_next;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 #(
    .MATRIX_PRIO(MATRIX_PRIO)
  ) u_pick (
    .m_req      (bus.m_req),
    .h_req      (bus.h_req),
    .last_owner (owner_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    we_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_ISSUE;
          owner_next = pick_winner;
          if (pick_winner == OWN_HOST) begin
            addr_next = bus.h_addr;
            data_next = bus.h_wdata;
            we_next   = bus.h_we;
          end else begin
            addr_next = bus.m_addr;
          end
        end
      end
      // we_reg doubles as the read/write flag of the access in flight
      ST_ISSUE: state_next = we_reg ? ST_IDLE : ST_RDATA;
      ST_RDATA: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_HOST;
      addr_reg  <= '0;
      data_reg  <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      we_reg    <= we_next;
    end
  end

  logic in_issue;
  logic in_rdata;

  assign in_issue = (state_reg == ST_ISSUE);
  // A read interrupted by reset in its data cycle is dropped, so no rvalid escapes
  assign in_rdata = (state_reg == ST_RDATA) && !reset;

  assign bus.m_gnt    = in_issue && (owner_reg == OWN_MATRIX);
  assign bus.h_gnt    = in_issue && (owner_reg == OWN_HOST);
  assign bus.m_rvalid = in_rdata && (owner_reg == OWN_MATRIX);
  assign bus.h_rvalid = in_rdata && (owner_reg == OWN_HOST);
  assign bus.m_rdata  = bus.q_b;
  assign bus.h_rdata  = bus.q_b;
  assign bus.addr_b   = addr_reg;
  assign bus.data_b   = data_reg;
  assign bus.we_b     = we_reg;
  assign bus.busy     = (state_reg != ST_IDLE);

endmodule
